// File: rtl/rf_write_arbiter_if.sv
// Writeback-to-register-file port bundle: two valid/ready requesters, clear control,
// status pulses and the registered register-file write port.
interface rf_write_arbiter_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 4
);
  logic              req0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;
  logic              clr_req;
  logic              clr_busy;
  logic              clr_done;
  logic              wr_drop;
  logic              rf_load;
  logic [ADDR_W-1:0] rf_caddr;
  logic [DATA_W-1:0] rf_c;

  // Writeback side: issues requests, observes the write port and status.
  modport master (
    output req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data, clr_req,
    input  req0_ready, req1_ready, clr_busy, clr_done, wr_drop, rf_load, rf_caddr, rf_c
  );

  // Arbiter side.
  modport slave (
    input  req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data, clr_req,
    output req0_ready, req1_ready, clr_busy, clr_done, wr_drop, rf_load, rf_caddr, rf_c
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter for the register file write port, with a one-register-per-cycle
// clear sweep. All register-file-facing outputs are registered; readies are combinational.
module rf_write_arbiter #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned NUM_REGS   = 16,
  parameter bit          PROTECT_R0 = 1'b0
) (
  input logic               clk,
  input logic               nClear,
  rf_write_arbiter_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(NUM_REGS + 1);

  typedef enum logic {ST_RUN, ST_CLEAR} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_grant_q, last_grant_d;
  logic              rf_load_q, rf_load_d;
  logic [ADDR_W-1:0] rf_caddr_q, rf_caddr_d;
  logic [DATA_W-1:0] rf_c_q, rf_c_d;
  logic              clr_busy_q, clr_busy_d;
  logic              clr_done_q, clr_done_d;
  logic              wr_drop_q, wr_drop_d;

  logic              accept_ok_c;
  logic              grant0_c, grant1_c, xfer_c, drop_c;
  logic [ADDR_W-1:0] sel_addr_c;
  logic [DATA_W-1:0] sel_data_c;

  // Grant: a lone requester wins; on a tie the one not granted last time wins.
  always_comb begin
    accept_ok_c = (state_q == ST_RUN) && !bus.clr_req && !nClear;
    grant0_c    = accept_ok_c && bus.req0_valid && (!bus.req1_valid || last_grant_q);
    grant1_c    = accept_ok_c && bus.req1_valid && (!bus.req0_valid || !last_grant_q);
    xfer_c      = grant0_c || grant1_c;
    sel_addr_c  = grant1_c ? bus.req1_addr : bus.req0_addr;
    sel_data_c  = grant1_c ? bus.req1_data : bus.req0_data;
    drop_c      = (PROTECT_R0 && (sel_addr_c == '0)) || (32'(sel_addr_c) >= NUM_REGS);
  end

  assign bus.req0_ready = grant0_c;
  assign bus.req1_ready = grant1_c;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    rf_load_d    = 1'b0;
    rf_caddr_d   = rf_caddr_q;
    rf_c_d       = rf_c_q;
    clr_busy_d   = clr_busy_q;
    clr_done_d   = 1'b0;
    wr_drop_d    = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (bus.clr_req) begin
          // First sweep write (address 0) issues on the entry edge itself.
          state_d    = ST_CLEAR;
          cnt_d      = CNT_W'(1);
          rf_load_d  = 1'b1;
          rf_caddr_d = '0;
          rf_c_d     = '0;
          clr_busy_d = 1'b1;
        end else if (xfer_c) begin
          last_grant_d = grant1_c;
          if (drop_c) begin
            wr_drop_d = 1'b1;
          end else begin
            rf_load_d  = 1'b1;
            rf_caddr_d = sel_addr_c;
            rf_c_d     = sel_data_c;
          end
        end
      end
      ST_CLEAR: begin
        if (cnt_q == CNT_W'(NUM_REGS)) begin
          state_d    = ST_RUN;
          cnt_d      = '0;
          clr_busy_d = 1'b0;
          clr_done_d = 1'b1;
        end else begin
          rf_load_d  = 1'b1;
          rf_caddr_d = ADDR_W'(cnt_q);
          rf_c_d     = '0;
          cnt_d      = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (nClear) begin
      state_q      <= ST_RUN;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      rf_load_q    <= 1'b0;
      rf_caddr_q   <= '0;
      rf_c_q       <= '0;
      clr_busy_q   <= 1'b0;
      clr_done_q   <= 1'b0;
      wr_drop_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      rf_load_q    <= rf_load_d;
      rf_caddr_q   <= rf_caddr_d;
      rf_c_q       <= rf_c_d;
      clr_busy_q   <= clr_busy_d;
      clr_done_q   <= clr_done_d;
      wr_drop_q    <= wr_drop_d;
    end
  end

  assign bus.rf_load  = rf_load_q;
  assign bus.rf_caddr = rf_caddr_q;
  assign bus.rf_c     = rf_c_q;
  assign bus.clr_busy = clr_busy_q;
  assign bus.clr_done = clr_done_q;
  assign bus.wr_drop  = wr_drop_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: one default instance and one with R0 protect and a
// 12-register range, driven from a vector table plus clear/reset sequences.
module tb_rf_write_arbiter;

  logic clk;
  logic nClear;
  int   n_cmp;
  int   n_bad;

  rf_write_arbiter_if #(.DATA_W(16), .ADDR_W(4)) bus0 ();
  rf_write_arbiter_if #(.DATA_W(16), .ADDR_W(4)) bus1 ();

  rf_write_arbiter #(.DATA_W(16), .ADDR_W(4), .NUM_REGS(16), .PROTECT_R0(1'b0)) dut0 (
    .clk(clk), .nClear(nClear), .bus(bus0)
  );
  rf_write_arbiter #(.DATA_W(16), .ADDR_W(4), .NUM_REGS(12), .PROTECT_R0(1'b1)) dut1 (
    .clk(clk), .nClear(nClear), .bus(bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sel;
    logic        v0;
    logic [3:0]  a0;
    logic [15:0] d0;
    logic        v1;
    logic [3:0]  a1;
    logic [15:0] d1;
    logic        r0;
    logic        r1;
    logic        load;
    logic [3:0]  caddr;
    logic [15:0] c;
    logic        drop;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic v0, input logic [3:0] a0, input logic [15:0] d0,
                        input logic v1, input logic [3:0] a1, input logic [15:0] d1);
    bus0.req0_valid = v0; bus0.req0_addr = a0; bus0.req0_data = d0;
    bus0.req1_valid = v1; bus0.req1_addr = a1; bus0.req1_data = d1;
  endtask

  task automatic drive1(input logic v0, input logic [3:0] a0, input logic [15:0] d0,
                        input logic v1, input logic [3:0] a1, input logic [15:0] d1);
    bus1.req0_valid = v0; bus1.req0_addr = a0; bus1.req0_data = d0;
    bus1.req1_valid = v1; bus1.req1_addr = a1; bus1.req1_data = d1;
  endtask

  function automatic vec_t mk(input logic sel,
                              input logic v0, input logic [3:0] a0, input logic [15:0] d0,
                              input logic v1, input logic [3:0] a1, input logic [15:0] d1,
                              input logic r0, input logic r1, input logic load,
                              input logic [3:0] caddr, input logic [15:0] c, input logic drop);
    vec_t v;
    v.sel = sel; v.v0 = v0; v.a0 = a0; v.d0 = d0; v.v1 = v1; v.a1 = a1; v.d1 = d1;
    v.r0 = r0; v.r1 = r1; v.load = load; v.caddr = caddr; v.c = c; v.drop = drop;
    return v;
  endfunction

  initial begin
    n_cmp = 0;
    n_bad = 0;
    nClear = 1'b1;
    bus0.clr_req = 1'b0;
    bus1.clr_req = 1'b0;
    drive1(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
    drive0(1'b1, 4'd3, 16'h1234, 1'b0, 4'd0, 16'h0);

    // Instance 0: default parameters. Instance 1: PROTECT_R0=1, NUM_REGS=12.
    vecs.push_back(mk(0, 1,4'd1,16'hAAAA, 1,4'd2,16'hBBBB, 1,0, 1,4'd1,16'hAAAA, 0));
    vecs.push_back(mk(0, 1,4'd1,16'hAAAA, 1,4'd2,16'hBBBB, 0,1, 1,4'd2,16'hBBBB, 0));
    vecs.push_back(mk(0, 1,4'd1,16'hAAAA, 1,4'd2,16'hBBBB, 1,0, 1,4'd1,16'hAAAA, 0));
    vecs.push_back(mk(0, 1,4'd1,16'hAAAA, 1,4'd2,16'hBBBB, 0,1, 1,4'd2,16'hBBBB, 0));
    vecs.push_back(mk(0, 1,4'd3,16'h1234, 0,4'd0,16'h0000, 1,0, 1,4'd3,16'h1234, 0));
    vecs.push_back(mk(0, 0,4'd0,16'h0000, 0,4'd0,16'h0000, 0,0, 0,4'd0,16'h0000, 0));
    vecs.push_back(mk(0, 0,4'd0,16'h0000, 1,4'd0,16'hFFFF, 0,1, 1,4'd0,16'hFFFF, 0));
    vecs.push_back(mk(0, 0,4'd0,16'h0000, 1,4'd7,16'h0707, 0,1, 1,4'd7,16'h0707, 0));
    vecs.push_back(mk(0, 1,4'd8,16'h0808, 1,4'd9,16'h0909, 1,0, 1,4'd8,16'h0808, 0));
    vecs.push_back(mk(1, 0,4'd0,16'h0000, 1,4'd0,16'hFFFF, 0,1, 0,4'd0,16'h0000, 1));
    vecs.push_back(mk(1, 1,4'd12,16'hC0C0, 0,4'd0,16'h0000, 1,0, 0,4'd0,16'h0000, 1));
    vecs.push_back(mk(1, 1,4'd11,16'hBEEF, 0,4'd0,16'h0000, 1,0, 1,4'd11,16'hBEEF, 0));
    vecs.push_back(mk(1, 1,4'd0,16'h1111, 1,4'd15,16'h2222, 0,1, 0,4'd0,16'h0000, 1));
    vecs.push_back(mk(1, 1,4'd5,16'h5555, 1,4'd6,16'h6666, 1,0, 1,4'd5,16'h5555, 0));
    vecs.push_back(mk(1, 1,4'd0,16'h0A0A, 0,4'd0,16'h0000, 1,0, 0,4'd0,16'h0000, 1));

    // Reset: outputs cleared and no grants even with a valid request.
    step(); step(); step();
    chk("rst_r0", 32'(bus0.req0_ready), 32'd0);
    chk("rst_load", 32'(bus0.rf_load), 32'd0);
    chk("rst_caddr", 32'(bus0.rf_caddr), 32'd0);
    chk("rst_c", 32'(bus0.rf_c), 32'd0);
    chk("rst_busy", 32'(bus0.clr_busy), 32'd0);
    chk("rst_done", 32'(bus0.clr_done), 32'd0);
    chk("rst_drop", 32'(bus0.wr_drop), 32'd0);
    nClear = 1'b0;
    drive0(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
    step();

    foreach (vecs[i]) begin
      if (vecs[i].sel) begin
        drive0(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
        drive1(vecs[i].v0, vecs[i].a0, vecs[i].d0, vecs[i].v1, vecs[i].a1, vecs[i].d1);
      end else begin
        drive1(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
        drive0(vecs[i].v0, vecs[i].a0, vecs[i].d0, vecs[i].v1, vecs[i].a1, vecs[i].d1);
      end
      #2;
      chk($sformatf("v%0d_r0", i), 32'(vecs[i].sel ? bus1.req0_ready : bus0.req0_ready), 32'(vecs[i].r0));
      chk($sformatf("v%0d_r1", i), 32'(vecs[i].sel ? bus1.req1_ready : bus0.req1_ready), 32'(vecs[i].r1));
      step();
      chk($sformatf("v%0d_load", i), 32'(vecs[i].sel ? bus1.rf_load : bus0.rf_load), 32'(vecs[i].load));
      chk($sformatf("v%0d_drop", i), 32'(vecs[i].sel ? bus1.wr_drop : bus0.wr_drop), 32'(vecs[i].drop));
      if (vecs[i].load) begin
        chk($sformatf("v%0d_caddr", i), 32'(vecs[i].sel ? bus1.rf_caddr : bus0.rf_caddr), 32'(vecs[i].caddr));
        chk($sformatf("v%0d_c", i), 32'(vecs[i].sel ? bus1.rf_c : bus0.rf_c), 32'(vecs[i].c));
      end
    end
    drive0(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
    drive1(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
    step();

    // Transfer, then clear request next cycle: write lands, then the sweep follows.
    drive0(1'b1, 4'd5, 16'h5555, 1'b0, 4'd0, 16'h0);
    #2 chk("pre_clr_r0", 32'(bus0.req0_ready), 32'd1);
    step();
    chk("land_load", 32'(bus0.rf_load), 32'd1);
    chk("land_caddr", 32'(bus0.rf_caddr), 32'd5);
    chk("land_c", 32'(bus0.rf_c), 32'h5555);
    bus0.clr_req = 1'b1;
    drive0(1'b1, 4'd6, 16'h6666, 1'b0, 4'd0, 16'h0);
    #2 chk("clr_entry_r0", 32'(bus0.req0_ready), 32'd0);
    step();
    bus0.clr_req = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("sw%0d_load", i), 32'(bus0.rf_load), 32'd1);
      chk($sformatf("sw%0d_caddr", i), 32'(bus0.rf_caddr), 32'(i));
      chk($sformatf("sw%0d_c", i), 32'(bus0.rf_c), 32'd0);
      chk($sformatf("sw%0d_busy", i), 32'(bus0.clr_busy), 32'd1);
      chk($sformatf("sw%0d_done", i), 32'(bus0.clr_done), 32'd0);
      if (i == 5) bus0.clr_req = 1'b1;
      if (i == 7) bus0.clr_req = 1'b0;
      #2 chk($sformatf("sw%0d_r0", i), 32'(bus0.req0_ready), 32'd0);
      step();
    end
    chk("done_load", 32'(bus0.rf_load), 32'd0);
    chk("done_busy", 32'(bus0.clr_busy), 32'd0);
    chk("done_pulse", 32'(bus0.clr_done), 32'd1);
    #2 chk("done_r0", 32'(bus0.req0_ready), 32'd1);
    step();
    chk("post_done", 32'(bus0.clr_done), 32'd0);
    chk("post_load", 32'(bus0.rf_load), 32'd1);
    chk("post_caddr", 32'(bus0.rf_caddr), 32'd6);
    chk("post_c", 32'(bus0.rf_c), 32'h6666);

    // clr_req held through the done cycle starts a second sweep.
    drive0(1'b1, 4'd9, 16'h9999, 1'b0, 4'd0, 16'h0);
    bus0.clr_req = 1'b1;
    step();
    for (int i = 0; i < 16; i++) step();
    chk("re_done", 32'(bus0.clr_done), 32'd1);
    #2 chk("re_r0", 32'(bus0.req0_ready), 32'd0);
    step();
    chk("re_load", 32'(bus0.rf_load), 32'd1);
    chk("re_caddr", 32'(bus0.rf_caddr), 32'd0);
    chk("re_busy", 32'(bus0.clr_busy), 32'd1);
    bus0.clr_req = 1'b0;
    step(); step(); step();
    chk("re3_caddr", 32'(bus0.rf_caddr), 32'd3);

    // Reset mid-sweep aborts it with no done pulse; first tie afterwards goes to req0.
    nClear = 1'b1;
    drive0(1'b1, 4'd1, 16'hAAAA, 1'b1, 4'd2, 16'hBBBB);
    #2 chk("abort_r0", 32'(bus0.req0_ready), 32'd0);
    step();
    chk("abort_load", 32'(bus0.rf_load), 32'd0);
    chk("abort_busy", 32'(bus0.clr_busy), 32'd0);
    chk("abort_done", 32'(bus0.clr_done), 32'd0);
    nClear = 1'b0;
    #2;
    chk("tie_r0", 32'(bus0.req0_ready), 32'd1);
    chk("tie_r1", 32'(bus0.req1_ready), 32'd0);
    step();
    chk("tie_caddr", 32'(bus0.rf_caddr), 32'd1);
    drive0(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("nodone%0d", i), 32'(bus0.clr_done | bus0.clr_busy), 32'd0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
